// File: rtl/stream_fifo.sv
// stream_fifo: synchronous stream FIFO carrying one data lane plus {A,F,L} flags with mflags/sflags handshake.
// Define STREAM_FIFO_PKT_EN to enable store-and-forward packet mode (head released only once a full packet is held).
module stream_fifo #(
    parameter int W          = 16,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [W-1:0]          uc_d0,
    input  logic [3:0]            uc_mflags,
    output logic [3:0]            cu_sflags,
    output logic [W-1:0]          cd_d0,
    output logic [3:0]            cd_mflags,
    input  logic [3:0]            dc_sflags,
    output logic [DEPTH_LOG2:0]   level
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2 + 1;
    localparam int AW    = DEPTH_LOG2 > 0 ? DEPTH_LOG2 : 1;

    logic [W+2:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_idx, rd_idx;
    logic [W+2:0]  head;
    logic          full, empty, vld, push, pop;
    logic          unused_dc_bits;

    assign unused_dc_bits = ^dc_sflags[3:1];

    assign wr_idx = DEPTH_LOG2 > 0 ? AW'(wr_ptr_q) : '0;
    assign rd_idx = DEPTH_LOG2 > 0 ? AW'(rd_ptr_q) : '0;
    assign level  = wr_ptr_q - rd_ptr_q;
    assign full   = level == PW'(DEPTH);
    assign empty  = wr_ptr_q == rd_ptr_q;
    assign head   = mem_q[rd_idx];

    // Full comes only from registered pointers, so a same-cycle pop never opens the input.
    assign push     = uc_mflags[0] & ~full;
    assign pop      = vld & ~dc_sflags[0];
    assign wr_ptr_d = wr_ptr_q + PW'(push);
    assign rd_ptr_d = rd_ptr_q + PW'(pop);

    assign cu_sflags = {3'b000, full};
    assign cd_d0     = head[W-1:0];
    assign cd_mflags = {vld ? head[W+2:W] : 3'b000, vld};

`ifdef STREAM_FIFO_PKT_EN
    logic [PW-1:0] pkt_cnt_q, pkt_cnt_d;

    // Count of complete packets (L beats) held; full also releases the head so over-long packets cannot deadlock.
    assign pkt_cnt_d = pkt_cnt_q + PW'(push & uc_mflags[1]) - PW'(pop & head[W]);
    assign vld       = ~empty & ((pkt_cnt_q != '0) | full);

    // Packet counter register.
    always_ff @(posedge clk) begin
        pkt_cnt_q <= rst ? '0 : pkt_cnt_d;
    end
`else
    assign vld = ~empty;
`endif

    // Storage array is deliberately not reset; stale entries are masked by V.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_idx] <= {uc_mflags[3:1], uc_d0};
    end

    // Read/write pointers; reset discards all entries including any beat in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end
endmodule

// File: tb/tb_stream_fifo.sv
// tb_stream_fifo: directed self-checking bench for stream_fifo (W=16, DEPTH=4).
module tb_stream_fifo;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] uc_d0 = 16'h0;
    logic [3:0]  uc_mflags = 4'h0;
    logic [3:0]  dc_sflags = 4'h0;
    logic [3:0]  cu_sflags, cd_mflags;
    logic [15:0] cd_d0;
    logic [2:0]  level;
    int          checks = 0;
    int          failures = 0;
    logic [18:0] src_q[$];
    logic [18:0] got_q[$];

    always #5 clk = ~clk;

    stream_fifo #(.W(16), .DEPTH_LOG2(2)) dut (
        .clk(clk), .rst(rst), .uc_d0(uc_d0), .uc_mflags(uc_mflags), .cu_sflags(cu_sflags),
        .cd_d0(cd_d0), .cd_mflags(cd_mflags), .dc_sflags(dc_sflags), .level(level)
    );

    // One clock of handshake: present src head upstream, record beats that complete at the coming edge.
    task automatic cyc(input logic bsy);
        dc_sflags = {3'b000, bsy};
        uc_mflags = src_q.size() > 0 ? {src_q[0][18:16], 1'b1} : 4'h0;
        uc_d0     = src_q.size() > 0 ? src_q[0][15:0] : 16'h0;
        if (cd_mflags[0] && !bsy) got_q.push_back({cd_mflags[3:1], cd_d0});
        if (uc_mflags[0] && !cu_sflags[0]) void'(src_q.pop_front());
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++; if (cd_mflags !== 4'h0) begin failures++; $display("FAIL reset_cd_mflags got=%h exp=0", cd_mflags); end
            checks++; if (cu_sflags !== 4'h0) begin failures++; $display("FAIL reset_cu_sflags got=%h exp=0", cu_sflags); end
            checks++; if (level !== 3'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
        end
        rst = 1'b0;
    endtask

    task automatic test_streaming;
        src_q.delete(); got_q.delete();
        for (int i = 1; i <= 16; i++) src_q.push_back({3'(i), 16'(i)});
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b0);
            checks++; if ({cd_mflags, cd_d0} !== {3'(i), 1'b1, 16'(i)}) begin failures++; $display("FAIL stream_head beat=%0d got=%h_%h exp=%h_%h", i, cd_mflags, cd_d0, {3'(i), 1'b1}, 16'(i)); end
            checks++; if (level !== 3'd1 || cu_sflags !== 4'h0) begin failures++; $display("FAIL stream_level beat=%0d level=%0d bsy=%h exp level=1 bsy=0", i, level, cu_sflags); end
        end
        cyc(1'b0);
        checks++; if (level !== 3'd0 || cd_mflags[0] !== 1'b0) begin failures++; $display("FAIL stream_empty level=%0d v=%b exp 0 0", level, cd_mflags[0]); end
        checks++; if (got_q.size() != 16) begin failures++; $display("FAIL stream_count got=%0d exp=16", got_q.size()); end
        for (int i = 0; i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== {3'(i + 1), 16'(i + 1)}) begin failures++; $display("FAIL stream_data idx=%0d got=%h exp=%h", i, got_q[i], {3'(i + 1), 16'(i + 1)}); end
        end
    endtask

    task automatic test_fill_drain;
        src_q.delete(); got_q.delete();
        for (int i = 0; i < 5; i++) src_q.push_back({3'b000, 16'(16'h11 + i)});
        for (int k = 1; k <= 4; k++) begin
            cyc(1'b1);
            checks++; if (level !== 3'(k) || cu_sflags !== {3'b000, k == 4}) begin failures++; $display("FAIL fill_level k=%0d level=%0d bsy=%h exp level=%0d bsy=%0d", k, level, cu_sflags, k, k == 4); end
        end
        repeat (2) begin
            cyc(1'b1);
            checks++; if (level !== 3'd4 || cu_sflags !== 4'h1 || cd_d0 !== 16'h11) begin failures++; $display("FAIL fill_hold level=%0d bsy=%h head=%h exp 4 1 0011", level, cu_sflags, cd_d0); end
            checks++; if (src_q.size() != 1 || got_q.size() != 0) begin failures++; $display("FAIL fill_held src=%0d out=%0d exp 1 0", src_q.size(), got_q.size()); end
        end
        cyc(1'b0);
        checks++; if (cu_sflags !== 4'h0 || level !== 3'd3 || cd_d0 !== 16'h12) begin failures++; $display("FAIL first_pop bsy=%h level=%0d head=%h exp 0 3 0012", cu_sflags, level, cd_d0); end
        for (int n = 0; n < 20 && (src_q.size() > 0 || cd_mflags[0]); n++) cyc(1'b0);
        checks++; if (got_q.size() != 5 || level !== 3'd0) begin failures++; $display("FAIL drain_count got=%0d level=%0d exp 5 0", got_q.size(), level); end
        for (int i = 0; i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== {3'b000, 16'(16'h11 + i)}) begin failures++; $display("FAIL drain_data idx=%0d got=%h exp=%h", i, got_q[i], 16'(16'h11 + i)); end
        end
    endtask

    task automatic test_wrap;
        int c;
        src_q.delete(); got_q.delete();
        for (int i = 0; i < 20; i++) src_q.push_back({3'(i % 8), 16'(16'h100 + i)});
        c = 0;
        while (c < 400 && (src_q.size() > 0 || cd_mflags[0])) begin
            cyc((c % 12) < 10);
            checks++; if (level > 3'd4) begin failures++; $display("FAIL wrap_level cycle=%0d level=%0d exp<=4", c, level); end
            c++;
        end
        checks++; if (got_q.size() != 20 || src_q.size() != 0) begin failures++; $display("FAIL wrap_count got=%0d left=%0d exp 20 0", got_q.size(), src_q.size()); end
        for (int i = 0; i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== {3'(i % 8), 16'(16'h100 + i)}) begin failures++; $display("FAIL wrap_data idx=%0d got=%h exp=%h", i, got_q[i], {3'(i % 8), 16'(16'h100 + i)}); end
        end
    endtask

    task automatic test_reset_mid;
        src_q.delete(); got_q.delete();
        for (int i = 0; i < 3; i++) src_q.push_back({3'b000, 16'(16'h31 + i)});
        repeat (3) cyc(1'b1);
        checks++; if (level !== 3'd3) begin failures++; $display("FAIL mid_level got=%0d exp=3", level); end
        rst = 1'b1; uc_mflags = 4'h1; uc_d0 = 16'h77; dc_sflags = 4'h0;
        @(negedge clk);
        rst = 1'b0; uc_mflags = 4'h0;
        checks++; if (level !== 3'd0 || cd_mflags !== 4'h0 || cu_sflags !== 4'h0) begin failures++; $display("FAIL mid_reset level=%0d v=%h bsy=%h exp 0 0 0", level, cd_mflags, cu_sflags); end
        src_q.push_back({3'b000, 16'h55});
        cyc(1'b0);
        checks++; if (cd_mflags !== 4'h1 || cd_d0 !== 16'h55 || level !== 3'd1) begin failures++; $display("FAIL mid_first flags=%h data=%h level=%0d exp 1 0055 1", cd_mflags, cd_d0, level); end
        cyc(1'b0);
        checks++; if (got_q.size() != 1 || got_q[0] !== 19'h00055 || level !== 3'd0) begin failures++; $display("FAIL mid_out count=%0d level=%0d exp 1 beat 0055 level 0", got_q.size(), level); end
    endtask

`ifdef STREAM_FIFO_PKT_EN
    task automatic test_pkt;
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        src_q.delete(); got_q.delete();
        src_q.push_back({3'b000, 16'hA1}); src_q.push_back({3'b000, 16'hA2}); src_q.push_back({3'b001, 16'hA3});
        for (int k = 1; k <= 3; k++) begin
            cyc(1'b0);
            checks++; if (cd_mflags[0] !== (k == 3)) begin failures++; $display("FAIL pkt_v k=%0d got=%b exp=%0d", k, cd_mflags[0], k == 3); end
        end
        for (int n = 0; n < 10 && cd_mflags[0]; n++) cyc(1'b0);
        checks++; if (got_q.size() != 3 || level !== 3'd0) begin failures++; $display("FAIL pkt_drain count=%0d level=%0d exp 3 0", got_q.size(), level); end
        for (int i = 0; i < 5; i++) src_q.push_back({3'b000, 16'(16'hB0 + i)});
        for (int k = 1; k <= 4; k++) begin
            cyc(1'b0);
            checks++; if (cd_mflags[0] !== (k == 4)) begin failures++; $display("FAIL pkt_full_v k=%0d got=%b exp=%0d", k, cd_mflags[0], k == 4); end
        end
        rst = 1'b1; src_q.delete(); uc_mflags = 4'h0; @(negedge clk); rst = 1'b0;
    endtask
`endif

    initial begin
        test_reset;
        test_streaming;
        test_fill_drain;
        test_wrap;
        test_reset_mid;
`ifdef STREAM_FIFO_PKT_EN
        test_pkt;
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end
endmodule
